bus_termination: RTL and testbench
==================================

// Module: bus_termination
// PURPOSE
// - 68030 cycle-termination controller, directly downstream of address_decode:
//   consumes the active-low request_* strobes, inserts per-target wait states and drives DSACK1/DSACK0/BERR.
// - Port size to the CPU by DSACK encoding: RAM 32-bit, ROM 16-bit, serial 8-bit, VME 16-bit.
// - VME cycles end on synchronised DTACK/BERR; a watchdog raises BERR on timeout; unmapped accesses get an immediate BERR.
// PARAMETERS
// - RAM_WAIT      1    clocks from request to DSACK for RAM (0 = next clock)
// - ROM_WAIT      3    clocks from request to DSACK for ROM
// - SERIAL_WAIT   4    clocks from request to DSACK for serial
// - TIMEOUT       255  clocks before BERR on a VME cycle with no DTACK/BERR
// - CNT_W         8    counter width; every *_WAIT and TIMEOUT must be < 2**CNT_W
// PORTS
// - clock            in   1  system clock; all state on rising edge
// - reset            in   1  asynchronous, active-low reset
// - cpu_as           in   1  CPU address strobe, active-low
// - request_ram      in   1  active-low, from address_decode
// - request_rom      in   1  active-low, from address_decode
// - request_serial   in   1  active-low, from address_decode
// - request_vme      in   1  active-low, AND of request_vme_a16/a24/a40
// - request_unmapped in   1  active-low, from address_decode
// - vme_dtack        in   1  VME DTACK*, active-low, asynchronous
// - vme_berr         in   1  VME BERR*, active-low, asynchronous
// - cpu_dsack        out  2  {DSACK1,DSACK0}, active-low: 00=32-bit, 01=16-bit, 10=8-bit, 11=none
// - cpu_berr         out  1  CPU BERR, active-low
// - busy             out  1  active-high, asserted whenever state != IDLE
// BEHAVIOUR
// - Reset (async, reset=0): state=IDLE, counter=0, cpu_dsack=2'b11, cpu_berr=1, busy=0, synchronisers=1.
// - All outputs are registered. vme_dtack/vme_berr pass through 2-flop synchronisers (2 clocks latency).
// - IDLE: when cpu_as=0 and exactly one request_* is 0, latch target and load counter:
//   - RAM/ROM/serial: load the *_WAIT value; go to WAIT.
//   - VME: load TIMEOUT; go to VWAIT.
//   - unmapped: go to ERR.
// - cpu_as=0 with no request active: remain in IDLE; the CPU's own watchdog handles the cycle.
// - WAIT: decrement counter each clock; when counter==0, go to ACK and drive the target's DSACK code.
//   - Total latency from request sample to DSACK visible = WAIT+1 clocks.
// - VWAIT priorities, highest first:
//   1. synced BERR=0 -> ERR
//   2. synced DTACK=0 -> ACK with 16-bit code (01)
//   3. counter==0 -> ERR (timeout)
//   - Otherwise decrement the counter.
// - ACK: hold cpu_dsack until cpu_as samples 1; then go to DONE.
// - ERR: hold cpu_berr=0 until cpu_as samples 1; then go to DONE.
// - DONE: cpu_dsack=11, cpu_berr=1; go to IDLE next clock.
//   - Guarantees one idle clock between cycles, so stale strobes never terminate the next cycle.
// - cpu_as negating in WAIT or VWAIT (aborted cycle): go to DONE with no DSACK/BERR.
// - DSACK and BERR are never asserted in the same clock; BERR wins any tie.
// - Counter never wraps: decrement only while non-zero.
// - Multiple request_* low at once (decoder fault): treat as unmapped -> ERR.
// - Async reset mid-cycle forces IDLE immediately, with outputs released in the same instant.
// STRUCTURE
// - Shared package: DSACK codes (DSACK_32=2'b00, DSACK_16=2'b01, DSACK_8=2'b10, DSACK_NONE=2'b11);
//   state encoding (IDLE, WAIT, VWAIT, ACK, ERR, DONE); ACTIVE/INACTIVE constants.
// - One sub-module: sync_2ff (one bit, async active-low reset to 1), instantiated for vme_dtack and vme_berr.
// - Remainder: one FSM block plus the counter, in this file.
// TESTING
// 1. RAM read, RAM_WAIT=1: cpu_as=0, request_ram=0
//    -> cpu_dsack=00 two clocks after sampling; released one clock after cpu_as=1.
// 2. Serial access, SERIAL_WAIT=4 -> cpu_dsack=10 on clock 5; ROM, ROM_WAIT=3 -> cpu_dsack=01 on clock 4.
// 3. VME with vme_dtack=0 asserted 10 clocks after request
//    -> cpu_dsack=01 within 3 clocks of DTACK; cpu_berr stays 1.
// 4. VME with no response, TIMEOUT=255 -> cpu_berr=0 at clock 256; cpu_dsack stays 11.
//    - Repeat with vme_berr and vme_dtack asserted together -> cpu_berr=0 only.
// 5. request_unmapped=0 -> cpu_berr=0 one clock later; request_ram and request_rom both 0 -> same response.
// 6. Abort: cpu_as=1 during WAIT -> no DSACK, DONE then IDLE.
//    - reset=0 mid-ACK -> cpu_dsack=11 and busy=0 immediately, without a clock edge.

Source files
------------

// File: rtl/bus_termination_pkg.sv
// Shared types and constants for the 68030 cycle-termination controller:
// DSACK port-size codes, strobe polarity, FSM states and target encoding.
package bus_termination_pkg;

  localparam int DSACK_W = 2;

  localparam logic [DSACK_W-1:0] DSACK_32   = 2'b00;
  localparam logic [DSACK_W-1:0] DSACK_16   = 2'b01;
  localparam logic [DSACK_W-1:0] DSACK_8    = 2'b10;
  localparam logic [DSACK_W-1:0] DSACK_NONE = 2'b11;

  // All CPU/VME strobes on this block are active-low.
  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_VWAIT,
    ST_ACK,
    ST_ERR,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    TGT_RAM,
    TGT_ROM,
    TGT_SERIAL,
    TGT_VME
  } target_t;

  // Port width each target presents to the CPU.
  function automatic logic [DSACK_W-1:0] dsack_for(input target_t tgt);
    case (tgt)
      TGT_RAM:    dsack_for = DSACK_32;
      TGT_ROM:    dsack_for = DSACK_16;
      TGT_SERIAL: dsack_for = DSACK_8;
      default:    dsack_for = DSACK_16;
    endcase
  endfunction

endpackage

// File: rtl/bus_termination_if.sv
// Bus-side signal bundle of the termination controller: CPU strobe, decoder
// requests, VME handshake inputs and the DSACK/BERR/busy outputs.
interface bus_termination_if;
  import bus_termination_pkg::*;

  logic               cpu_as;
  logic               request_ram;
  logic               request_rom;
  logic               request_serial;
  logic               request_vme;
  logic               request_unmapped;
  logic               vme_dtack;
  logic               vme_berr;
  logic [DSACK_W-1:0] cpu_dsack;
  logic               cpu_berr;
  logic               busy;

  modport master (
    output cpu_as, request_ram, request_rom, request_serial, request_vme,
           request_unmapped, vme_dtack, vme_berr,
    input  cpu_dsack, cpu_berr, busy
  );

  modport slave (
    input  cpu_as, request_ram, request_rom, request_serial, request_vme,
           request_unmapped, vme_dtack, vme_berr,
    output cpu_dsack, cpu_berr, busy
  );

endinterface

// File: rtl/bus_termination_sync_2ff.sv
// Two-flop synchroniser for one active-low asynchronous VME strobe;
// resets to the inactive level so a reset never looks like a response.
module sync_2ff
  import bus_termination_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_meta <= INACTIVE;
      r_sync <= INACTIVE;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/bus_termination.sv
// 68030 cycle-termination controller: turns decoder requests into DSACK/BERR
// after per-target wait states, with a DTACK/BERR-terminated, watchdogged VME path.
module bus_termination
  import bus_termination_pkg::*;
#(
  parameter int RAM_WAIT    = 1,
  parameter int ROM_WAIT    = 3,
  parameter int SERIAL_WAIT = 4,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 8
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  bus_termination_if.slave bt
);

  localparam logic [CNT_W-1:0] L_RAM_WAIT    = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] L_ROM_WAIT    = CNT_W'(ROM_WAIT);
  localparam logic [CNT_W-1:0] L_SERIAL_WAIT = CNT_W'(SERIAL_WAIT);
  localparam logic [CNT_W-1:0] L_TIMEOUT     = CNT_W'(TIMEOUT);

  state_t             r_state;
  target_t            r_target;
  logic [CNT_W-1:0]   r_cnt;
  logic [DSACK_W-1:0] r_dsack;
  logic               r_berr;
  logic               r_busy;

  logic               w_dtack_s;
  logic               w_berr_s;
  logic [4:0]         w_req;
  logic               w_one_hot;
  target_t            w_tgt;
  logic [CNT_W-1:0]   w_load;

  sync_2ff u_sync_dtack (.i_clock(i_clock), .i_reset_n(i_reset_n), .i_d(bt.vme_dtack), .o_q(w_dtack_s));
  sync_2ff u_sync_berr  (.i_clock(i_clock), .i_reset_n(i_reset_n), .i_d(bt.vme_berr),  .o_q(w_berr_s));

  // Active-high request vector: {unmapped, vme, serial, rom, ram}.
  assign w_req = ~{bt.request_unmapped, bt.request_vme, bt.request_serial,
                   bt.request_rom, bt.request_ram};
  assign w_one_hot = (w_req != 5'd0) && ((w_req & (w_req - 5'd1)) == 5'd0);

  always_comb begin
    w_tgt  = TGT_RAM;
    w_load = L_RAM_WAIT;
    if (w_req[1]) begin
      w_tgt  = TGT_ROM;
      w_load = L_ROM_WAIT;
    end else if (w_req[2]) begin
      w_tgt  = TGT_SERIAL;
      w_load = L_SERIAL_WAIT;
    end else if (w_req[3]) begin
      w_tgt  = TGT_VME;
      w_load = L_TIMEOUT;
    end
  end

  // Outputs are registered alongside each transition so DSACK/BERR appear on
  // the same edge the FSM enters ACK/ERR and drop on the edge it leaves.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= ST_IDLE;
      r_target <= TGT_RAM;
      r_cnt    <= '0;
      r_dsack  <= DSACK_NONE;
      r_berr   <= INACTIVE;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_dsack <= DSACK_NONE;
          r_berr  <= INACTIVE;
          if (bt.cpu_as == ACTIVE && w_req != 5'd0) begin
            r_busy <= 1'b1;
            if (!w_one_hot || w_req[4]) begin
              r_state <= ST_ERR;
              r_berr  <= ACTIVE;
            end else begin
              r_target <= w_tgt;
              r_cnt    <= w_load;
              r_state  <= (w_tgt == TGT_VME) ? ST_VWAIT : ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (bt.cpu_as == INACTIVE) begin
            r_state <= ST_DONE;
          end else if (r_cnt == '0) begin
            r_state <= ST_ACK;
            r_dsack <= dsack_for(r_target);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_VWAIT: begin
          if (bt.cpu_as == INACTIVE) begin
            r_state <= ST_DONE;
          end else if (w_berr_s == ACTIVE || (w_dtack_s == INACTIVE && r_cnt == '0)) begin
            r_state <= ST_ERR;
            r_berr  <= ACTIVE;
          end else if (w_dtack_s == ACTIVE) begin
            r_state <= ST_ACK;
            r_dsack <= DSACK_16;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_ACK, ST_ERR: begin
          if (bt.cpu_as == INACTIVE) begin
            r_state <= ST_DONE;
            r_dsack <= DSACK_NONE;
            r_berr  <= INACTIVE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_dsack <= DSACK_NONE;
          r_berr  <= INACTIVE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_dsack <= DSACK_NONE;
          r_berr  <= INACTIVE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bt.cpu_dsack = r_dsack;
  assign bt.cpu_berr  = r_berr;
  assign bt.busy      = r_busy;

endmodule

// File: tb/tb_bus_termination.sv
// Directed bench for bus_termination: a vector table of single-target cycles
// plus hand-written VME, abort, idle-strobe and mid-cycle reset sequences.
module tb_bus_termination;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  bus_termination_if bus ();

  bus_termination #(
    .RAM_WAIT(1), .ROM_WAIT(3), .SERIAL_WAIT(4), .TIMEOUT(255), .CNT_W(8)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bt       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // req bits (active-high here): {unmapped, vme, serial, rom, ram}
  typedef struct {
    logic [4:0] req;
    int         lat;
    logic [1:0] dsack;
    logic       berr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic [4:0] req);
    bus.request_ram      = ~req[0];
    bus.request_rom      = ~req[1];
    bus.request_serial   = ~req[2];
    bus.request_vme      = ~req[3];
    bus.request_unmapped = ~req[4];
  endtask

  // Counts edges from the sampling edge (k=1) until DSACK or BERR shows; -1 on timeout.
  task automatic wait_resp(input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (bus.cpu_dsack !== 2'b11 || bus.cpu_berr !== 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic end_cycle(input string name);
    bus.cpu_as = 1'b1;
    set_req(5'b0);
    @(posedge clk);
    #1;
    check({name, " release dsack"}, 32'(bus.cpu_dsack), 32'h3);
    check({name, " release berr"}, 32'(bus.cpu_berr), 32'h1);
    check({name, " done busy"}, 32'(bus.busy), 32'h1);
    @(posedge clk);
    #1;
    check({name, " idle busy"}, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    int k;
    logic seen;
    n_vec = 0;
    n_bad = 0;

    vecs[0] = '{req: 5'b00001, lat: 2,   dsack: 2'b00, berr: 1'b1}; // RAM
    vecs[1] = '{req: 5'b00010, lat: 4,   dsack: 2'b01, berr: 1'b1}; // ROM
    vecs[2] = '{req: 5'b00100, lat: 5,   dsack: 2'b10, berr: 1'b1}; // serial
    vecs[3] = '{req: 5'b10000, lat: 0,   dsack: 2'b11, berr: 1'b0}; // unmapped
    vecs[4] = '{req: 5'b00011, lat: 0,   dsack: 2'b11, berr: 1'b0}; // RAM+ROM fault
    vecs[5] = '{req: 5'b01100, lat: 0,   dsack: 2'b11, berr: 1'b0}; // VME+serial fault
    vecs[6] = '{req: 5'b01000, lat: 256, dsack: 2'b11, berr: 1'b0}; // VME timeout

    rst_n         = 1'b0;
    bus.cpu_as    = 1'b1;
    bus.vme_dtack = 1'b1;
    bus.vme_berr  = 1'b1;
    set_req(5'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset dsack", 32'(bus.cpu_dsack), 32'h3);
    check("reset berr", 32'(bus.cpu_berr), 32'h1);
    check("reset busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 7; v++) begin
      bus.cpu_as = 1'b0;
      set_req(vecs[v].req);
      wait_resp(300, k);
      check($sformatf("vec%0d latency", v), 32'(k - 1), 32'(vecs[v].lat));
      check($sformatf("vec%0d dsack", v), 32'(bus.cpu_dsack), 32'(vecs[v].dsack));
      check($sformatf("vec%0d berr", v), 32'(bus.cpu_berr), 32'(vecs[v].berr));
      check($sformatf("vec%0d busy", v), 32'(bus.busy), 32'h1);
      $display("vec%0d req=%b lat=%0d dsack=%b berr=%b", v, vecs[v].req, k - 1,
               bus.cpu_dsack, bus.cpu_berr);
      end_cycle($sformatf("vec%0d", v));
    end

    // VME terminated by DTACK arriving 10 clocks into the cycle
    bus.cpu_as = 1'b0;
    set_req(5'b01000);
    repeat (10) @(posedge clk);
    #1;
    check("vme pre-dtack dsack", 32'(bus.cpu_dsack), 32'h3);
    bus.vme_dtack = 1'b0;
    wait_resp(20, k);
    check("vme dtack latency", 32'(k), 32'd3);
    check("vme dtack dsack", 32'(bus.cpu_dsack), 32'h1);
    check("vme dtack berr", 32'(bus.cpu_berr), 32'h1);
    $display("vme dtack: edges=%0d dsack=%b berr=%b", k, bus.cpu_dsack, bus.cpu_berr);
    bus.vme_dtack = 1'b1;
    end_cycle("vme dtack");
    repeat (3) @(posedge clk);
    #1;

    // VME with BERR and DTACK together: BERR wins
    bus.cpu_as    = 1'b0;
    set_req(5'b01000);
    bus.vme_dtack = 1'b0;
    bus.vme_berr  = 1'b0;
    wait_resp(20, k);
    check("vme tie latency", 32'(k), 32'd3);
    check("vme tie dsack", 32'(bus.cpu_dsack), 32'h3);
    check("vme tie berr", 32'(bus.cpu_berr), 32'h0);
    $display("vme tie: edges=%0d dsack=%b berr=%b", k, bus.cpu_dsack, bus.cpu_berr);
    bus.vme_dtack = 1'b1;
    bus.vme_berr  = 1'b1;
    end_cycle("vme tie");
    repeat (3) @(posedge clk);
    #1;

    // Abort during serial WAIT: no DSACK ever, DONE then IDLE
    bus.cpu_as = 1'b0;
    set_req(5'b00100);
    repeat (2) @(posedge clk);
    #1;
    end_cycle("abort");
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.cpu_dsack !== 2'b11 || bus.busy !== 1'b0) seen = 1'b1;
    end
    check("abort stays quiet", 32'(seen), 32'h0);
    $display("abort: quiet=%b", ~seen);

    // AS with no request stays IDLE
    bus.cpu_as = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.busy !== 1'b0 || bus.cpu_berr !== 1'b1) seen = 1'b1;
    end
    check("no-request idle", 32'(seen), 32'h0);
    $display("no request: idle=%b", ~seen);
    bus.cpu_as = 1'b1;
    @(posedge clk);
    #1;

    // Async reset mid-ACK releases outputs without a clock edge
    bus.cpu_as = 1'b0;
    set_req(5'b00001);
    wait_resp(10, k);
    check("pre-reset dsack", 32'(bus.cpu_dsack), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset dsack", 32'(bus.cpu_dsack), 32'h3);
    check("async reset busy", 32'(bus.busy), 32'h0);
    check("async reset berr", 32'(bus.cpu_berr), 32'h1);
    $display("async reset: dsack=%b busy=%b", bus.cpu_dsack, bus.busy);
    bus.cpu_as = 1'b1;
    set_req(5'b0);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
